// File: rtl/key_mode_if.sv
// Button-in / mode-out bundle between the key controller and the LED pattern stage.
interface key_mode_if;
  logic       key_n;
  logic [1:0] mode;
  logic       mode_valid;
  logic       tick;
  logic [7:0] press_cnt;

  modport master (output key_n, input mode, mode_valid, tick, press_cnt);
  modport slave  (input key_n, output mode, mode_valid, tick, press_cnt);
endinterface

// File: rtl/key_mode_ctrl.sv
// Button synchroniser/debouncer, 2-bit mode stepper with long-press reset,
// and the phase-realigned step tick for the LED pattern stage.
module key_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int HOLD_CYCLES     = 100,
  parameter int TICK_DIV        = 5
) (
  input logic       clk,
  input logic       rst_n,
  key_mode_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic [1:0]    sync_pipe;
  logic          key_s;
  logic [1:0]    state;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic [TW-1:0] tcnt;
  logic          held;
  logic          accept, long_fire, mode_wr;
  logic [1:0]    mode_q;
  logic          mode_valid_q, tick_q;
  logic [7:0]    press_cnt_q;

  assign key_s     = sync_pipe[1];
  assign accept    = (state == PRESS_WAIT) && !key_s && (dcnt == D_LAST);
  assign long_fire = (state == PRESSED) && !key_s && !held && (hcnt == H_LAST);
  assign mode_wr   = accept | long_fire;

  // Both sync flops idle high so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= 2'b11;
    else        sync_pipe <= {sync_pipe[0], bus.key_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dcnt  <= '0;
      hcnt  <= '0;
      held  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          held <= 1'b0;
          if (!key_s) begin
            state <= PRESS_WAIT;
            dcnt  <= DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (key_s) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (accept) begin
            state <= PRESSED;
            hcnt  <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (key_s) begin
            state <= RELEASE_WAIT;
            dcnt  <= DW'(1);
          end else if (long_fire) begin
            held <= 1'b1;
          end else if (!held) begin
            hcnt <= hcnt + 1'b1;
          end
        end
        RELEASE_WAIT: begin
          // hcnt/held survive a release bounce so the hold neither restarts nor re-fires
          if (!key_s) begin
            state <= PRESSED;
            dcnt  <= '0;
          end else if (dcnt == D_LAST) begin
            state <= IDLE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= 2'd0;
      mode_valid_q <= 1'b0;
      press_cnt_q  <= 8'd0;
    end else begin
      mode_valid_q <= mode_wr;
      if (accept) begin
        mode_q      <= mode_q + 2'd1;
        press_cnt_q <= press_cnt_q + 8'd1;
      end else if (long_fire) begin
        mode_q <= 2'd0;
      end
    end
  end

  // A mode write restarts the tick phase so the new pattern starts aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt   <= '0;
      tick_q <= 1'b0;
    end else if (mode_wr) begin
      tcnt   <= '0;
      tick_q <= 1'b0;
    end else if (tcnt == T_LAST) begin
      tcnt   <= '0;
      tick_q <= 1'b1;
    end else begin
      tcnt   <= tcnt + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign bus.mode       = mode_q;
  assign bus.mode_valid = mode_valid_q;
  assign bus.tick       = tick_q;
  assign bus.press_cnt  = press_cnt_q;
endmodule

// File: doc/key_mode_ctrl.md
# key_mode_ctrl

Upstream control stage for the LED pattern block. It synchronises and debounces the active-low push-button input and steps a 2-bit pattern mode on each accepted press. A long press returns the mode to 0. It also generates the periodic step enable (`tick`) that the LED stage advances on.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20: consecutive stable synchronised samples needed to accept a press or a release; minimum 2.
- `HOLD_CYCLES`, default 100: cycles held in PRESSED before the long-press action fires; minimum 2.
- `TICK_DIV`, default 5: `tick` period in clocks; minimum 2.

Ports:
- `clk`  in  1: single system clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `key_n`  in  1: raw button, asynchronous, 0 = pressed.
- `mode`  out  2: current pattern mode, 0..3.
- `mode_valid`  out  1: one-cycle pulse whenever `mode` is written.
- `tick`  out  1: one-cycle step enable, every `TICK_DIV` clocks.
- `press_cnt`  out  8: count of accepted short presses; wraps 255→0.

## Operation
- Synchroniser: two flops, `s1<=key_n`, `s2<=s1`. The FSM uses only `key_s = s2`. Both flops reset to 1.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Registers: debounce counter `dcnt`, hold counter `hcnt`, flag `held`.
- IDLE:
  - `key_s==0` → PRESS_WAIT, `dcnt<=1`.
  - `held<=0`.
- PRESS_WAIT:
  - `key_s==1` → IDLE, `dcnt<=0`. This is a bounce; no output change.
  - `key_s==0` and `dcnt==DEBOUNCE_CYCLES-1` → PRESSED. Same edge: `mode<=mode+1` (mod 4, so 3→0), `mode_valid<=1`, `press_cnt<=press_cnt+1`, `hcnt<=0`.
  - Otherwise `dcnt<=dcnt+1`.
- PRESSED:
  - `key_s==1` → RELEASE_WAIT, `dcnt<=1`.
  - `key_s==0` and `held==0` and `hcnt==HOLD_CYCLES-1` → long press. Same edge: `mode<=0`, `mode_valid<=1`, `held<=1`. `press_cnt` is unchanged.
  - Otherwise, if `held==0`, `hcnt<=hcnt+1`.
  - Once `held==1`, no further action until release.
- RELEASE_WAIT:
  - `key_s==0` → PRESSED, `dcnt<=0`. `hcnt` and `held` are kept, so a release bounce neither restarts nor re-fires the hold.
  - `key_s==1` and `dcnt==DEBOUNCE_CYCLES-1` → IDLE.
  - Otherwise `dcnt<=dcnt+1`.
- Tick generator:
  - `tcnt` counts 0..`TICK_DIV-1`.
  - `tick<=1` on the edge where `tcnt` wraps to 0; otherwise `tick<=0`.
  - On any edge that writes `mode`: `tcnt<=0` and `tick<=0`, so the new pattern starts phase-aligned.
- Counter widths: `$clog2` of (parameter value + 1). No counter saturates or overflows within its range.

## Timing
- Reset (async assert) values: `mode=0`, `mode_valid=0`, `tick=0`, `press_cnt=0`, state IDLE, `dcnt=hcnt=tcnt=0`, `held=0`, `s1=s2=1`.
- Reset release: the first `tick` is high in the cycle after edge `TICK_DIV`. `tick` repeats every `TICK_DIV` edges after that.
- Press latency: let edge 0 be the first edge at which `s1` samples `key_n`=0. With `key_n` held low, `mode` updates and `mode_valid` rises at edge `DEBOUNCE_CYCLES+1`.
- `mode_valid` is high for exactly one cycle. `mode` is stable whenever `mode_valid` is high.
- Bounce rejection: any low run shorter than `DEBOUNCE_CYCLES` synchronised samples produces no output change.
- Long press: `mode_valid` pulses a second time `HOLD_CYCLES` edges after the press-accept edge, provided `key_s` stays 0 throughout.
- Re-arm: a new press is accepted only after `DEBOUNCE_CYCLES` consecutive high samples have returned the FSM to IDLE.
- Press-accept and tick wrap on the same edge: the mode write wins, so `tick=0` and `tcnt=0`.
- Reset mid-press: all state clears immediately. If the key is still low after reset deasserts, it is treated as a new press and fully re-debounced.

## Test plan
- Reset, then idle with `key_n=1` (D=20, TICK_DIV=5) → `mode=0`, `press_cnt=0`, `tick` pulses one cycle every 5 clocks.
- Clean press of 40 cycles, then release → `mode` becomes 1 at edge 21 with a single `mode_valid` pulse; `press_cnt=1`; `tcnt` restarts so the next `tick` is 5 edges later.
- Bouncy press: low 5 cycles, high 3, low 8, high 2, then low 30 → exactly one accept, 21 edges after the start of the final low run; `mode=1`.
- Four clean presses, each separated by ≥25 high cycles → `mode` sequence 1, 2, 3, 0; `press_cnt=4`.
- Long press (HOLD=100): from `mode=2`, hold 150 cycles → `mode=3` at accept, then `mode=0` 100 edges later; exactly 2 `mode_valid` pulses; `press_cnt` incremented once.
- Assert `rst_n`=0 during PRESS_WAIT, then release with `key_n` still low → all outputs 0 during reset; afterwards the press is accepted 21 edges after the first post-reset low sample.
